// File: rtl/jh_pad_feeder.sv
// ---------------------------------------------------------------------------
// jh_pad_feeder
//
// Purpose:
//   Front end of the JH-512 datapath. Collects a byte-aligned message arriving
//   as 64-bit words, packs it into 512-bit blocks and appends JH padding:
//   a single 1 bit (0x80 byte), zero fill, then the 128-bit big-endian message
//   bit length in the last 128 bits of the final block. Blocks are handed to
//   the F8 compression stage over a valid/ready handshake, with blk_last
//   marking the block whose F8 output is the digest.
//
// Parameters:
//   LEN_W      width of the message bit-length counter (wraps silently),
//              zero-extended into the 128-bit length field.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset, discards any partial message
//   in_data    message word, first byte in [63:56]
//   in_valid   in_data is qualified
//   in_ready   a word is accepted this cycle when in_valid is also high
//   in_last    the word is the final word of the message
//   in_bytes   valid bytes (0..8, MSB-aligned) in a last word; ignored and
//              treated as 8 on non-last words
//   blk_data   512-bit block, byte 0 in [511:504]
//   blk_valid  blk_data is qualified
//   blk_ready  F8 stage consumes the block this cycle
//   blk_last   blk_data is the final padded block of the message
// ---------------------------------------------------------------------------
module jh_pad_feeder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [3:0]   in_bytes,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_last
);

    typedef enum logic [1:0] {
        FILL,
        HOLD_DATA,
        HOLD_FINAL
    } state_t;

    state_t             state;

    // Assembly buffer and its write position (word index within the block).
    logic [511:0]       asm_buf;
    logic [2:0]         word_idx;

    // Running message length in bits.
    logic [LEN_W-1:0]   len_bits;

    // A length-only final block still has to follow the data block on
    // display; final_marker says whether it must also carry the 0x80 byte
    // (message ended exactly on a block boundary).
    logic               final_pending;
    logic               final_marker;

    // Combinational helpers for the word being offered.
    logic               accept;
    logic [3:0]         eff_bytes;
    logic [63:0]        word_masked;
    logic [6:0]         fill_k;
    logic [511:0]       asm_next;
    logic [LEN_W-1:0]   len_next;

    // Builds the closing block: optional 0x80 marker in byte 0, zeros, and
    // the zero-extended bit length in the bottom 128 bits.
    function automatic logic [511:0] make_final(input logic             marker,
                                                input logic [LEN_W-1:0] len);
        logic [511:0] blk;
        blk = '0;
        if (marker) begin
            blk[511:504] = 8'h80;
        end
        blk[127:0] = 128'(len);
        return blk;
    endfunction

    // in_ready depends on rst directly so that it reads 0 during the very
    // cycle reset is asserted, not only after the reset edge. Outside FILL a
    // block is being presented, so input is always stalled under backpressure.
    assign in_ready = (state == FILL) && !rst;
    assign accept   = in_valid && in_ready;

    // Work out what the assembly buffer would look like if the offered word
    // were accepted now: mask off bytes past the valid count, drop the word
    // into its slot, and on a short last word place the 0x80 marker directly
    // behind the final message byte. Slots after the current word are
    // already zero because the buffer is cleared each time a block is
    // registered, so no explicit zero fill is needed here.
    always_comb begin
        eff_bytes = 4'd8;
        if (in_last && (in_bytes <= 4'd8)) begin
            eff_bytes = in_bytes;
        end

        word_masked = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < eff_bytes) begin
                word_masked[63-8*b -: 8] = in_data[63-8*b -: 8];
            end
        end

        // Message bytes in this block once the word lands (0..64).
        fill_k = {1'b0, word_idx, 3'b000} + {3'b000, eff_bytes};

        asm_next = asm_buf;
        for (int w = 0; w < 8; w++) begin
            if (word_idx == 3'(w)) begin
                asm_next[511-64*w -: 64] = word_masked;
            end
        end

        // The marker may land in the next word slot when the last word was
        // full, which is why it is placed by byte index over the whole block.
        if (in_last && (fill_k != 7'd0) && (fill_k < 7'd64)) begin
            for (int b = 0; b < 64; b++) begin
                if (fill_k == 7'(b)) begin
                    asm_next[511-8*b -: 8] = 8'h80;
                end
            end
        end

        len_next = len_bits + LEN_W'({eff_bytes, 3'b000});
    end

    // Main controller. FILL collects words; a completed block is copied into
    // blk_data and the assembly buffer is freed at the same edge, so blk_data
    // is the only copy that has to stay stable during backpressure.
    // HOLD_DATA presents a data block and, if the message ended inside it,
    // swaps in the length block on handshake without a valid bubble.
    // HOLD_FINAL presents the last block and clears the per-message state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            asm_buf       <= '0;
            word_idx      <= '0;
            len_bits      <= '0;
            final_pending <= 1'b0;
            final_marker  <= 1'b0;
            blk_data      <= '0;
            blk_valid     <= 1'b0;
            blk_last      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        len_bits <= len_next;
                        if (in_last) begin
                            asm_buf  <= '0;
                            word_idx <= '0;
                            if (fill_k == 7'd0) begin
                                // Nothing in this block: only the closing
                                // block with the marker and length remains.
                                blk_data      <= make_final(1'b1, len_next);
                                blk_valid     <= 1'b1;
                                blk_last      <= 1'b1;
                                final_pending <= 1'b0;
                                state         <= HOLD_FINAL;
                            end else begin
                                blk_data      <= asm_next;
                                blk_valid     <= 1'b1;
                                blk_last      <= 1'b0;
                                final_pending <= 1'b1;
                                final_marker  <= (fill_k == 7'd64);
                                state         <= HOLD_DATA;
                            end
                        end else if (word_idx == 3'd7) begin
                            blk_data      <= asm_next;
                            blk_valid     <= 1'b1;
                            blk_last      <= 1'b0;
                            final_pending <= 1'b0;
                            asm_buf       <= '0;
                            word_idx      <= '0;
                            state         <= HOLD_DATA;
                        end else begin
                            asm_buf  <= asm_next;
                            word_idx <= word_idx + 3'd1;
                        end
                    end
                end

                HOLD_DATA: begin
                    if (blk_ready) begin
                        if (final_pending) begin
                            blk_data      <= make_final(final_marker, len_bits);
                            blk_last      <= 1'b1;
                            final_pending <= 1'b0;
                            state         <= HOLD_FINAL;
                        end else begin
                            blk_valid <= 1'b0;
                            state     <= FILL;
                        end
                    end
                end

                HOLD_FINAL: begin
                    if (blk_ready) begin
                        blk_valid     <= 1'b0;
                        blk_last      <= 1'b0;
                        len_bits      <= '0;
                        asm_buf       <= '0;
                        word_idx      <= '0;
                        final_pending <= 1'b0;
                        final_marker  <= 1'b0;
                        state         <= FILL;
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jh_pad_feeder.sv
// ---------------------------------------------------------------------------
// tb_jh_pad_feeder
//
// Purpose:
//   Self-checking bench for jh_pad_feeder. Directed messages come from a
//   table of {message, expected outputs}; hand-written sequences cover reset,
//   mid-message reset and output backpressure; random messages with random
//   gaps and random blk_ready are checked against a byte-level JH padding
//   model (message || 0x80 || zeros || 128-bit length, cut into 64-byte
//   blocks).
// ---------------------------------------------------------------------------
module tb_jh_pad_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [3:0]   in_bytes;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_last;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } blk_t;
    typedef blk_t blk_q_t[$];
    typedef byte unsigned msg_q_t[$];

    typedef struct {
        string        name;
        int           nbytes;
        int           pattern;
        int           exp_nblk;
        logic [63:0]  exp_word0;
        logic [127:0] exp_len;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    blk_t   obs_q[$];
    int     sink_mode = 0;

    always #5 clk = ~clk;

    jh_pad_feeder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_last  (blk_last)
    );

    task automatic checkOutput(input string name, input logic [511:0] act,
                               input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: JH padding computed on a byte array.
    function automatic void build_expected(input msg_q_t msg, output blk_q_t exp);
        int              len;
        int              plen;
        longint unsigned bits;
        byte unsigned    pb[];
        blk_t            blk;
        exp.delete();
        len  = msg.size();
        plen = len + 64 + ((64 - (len % 64)) % 64);
        pb   = new[plen];
        foreach (pb[i]) pb[i] = 8'h00;
        for (int i = 0; i < len; i++) pb[i] = msg[i];
        pb[len] = 8'h80;
        bits = longint'(len) * 8;
        for (int i = 0; i < 8; i++) pb[plen-1-i] = 8'(bits >> (8*i));
        for (int b = 0; b < plen/64; b++) begin
            blk.data = '0;
            for (int j = 0; j < 64; j++) blk.data[511-8*j -: 8] = pb[64*b+j];
            blk.last = (b == plen/64 - 1);
            exp.push_back(blk);
        end
    endfunction

    task automatic compare_model(input string tag, input msg_q_t msg);
        blk_q_t exp;
        build_expected(msg, exp);
        checkOutput({tag, "_nblk"}, 512'(obs_q.size()), 512'(exp.size()));
        foreach (exp[i]) begin
            if (i < obs_q.size()) begin
                checkOutput({tag, "_data"}, obs_q[i].data, exp[i].data);
                checkOutput({tag, "_last"}, 512'(obs_q[i].last), 512'(exp[i].last));
            end
        end
    endtask

    // Offers one word until accepted; returns at 1 time unit after the
    // accepting edge.
    task automatic send_word(input logic [63:0] d, input logic last,
                             input logic [3:0] nb, output bit ok);
        int budget;
        bit rdy;
        budget   = 300;
        ok       = 1'b0;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        while (budget > 0 && !ok) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
            budget--;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL accept_timeout: got no acceptance expected acceptance");
        end
    endtask

    task automatic wait_blocks(input int n);
        int budget;
        budget = 3000;
        while (obs_q.size() < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL block_timeout: got %0d blocks expected %0d", obs_q.size(), n);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends a whole message and waits for all of its blocks.
    task automatic applyStimulus(input msg_q_t msg, input bit empty_tail, input bit gaps);
        int          len, nfull, rem, nwords, pos, nexp;
        bit          ok, last;
        logic [63:0] w;
        logic [3:0]  nb, nb_drive;
        obs_q.delete();
        len    = msg.size();
        nfull  = len / 8;
        rem    = len % 8;
        nwords = (rem != 0 || len == 0 || empty_tail) ? nfull + 1 : nfull;
        pos    = 0;
        for (int i = 0; i < nwords; i++) begin
            last = (i == nwords - 1);
            nb   = (i < nfull) ? 4'd8 : 4'(rem);
            for (int b = 0; b < 8; b++) begin
                if (b < int'(nb)) w[63-8*b -: 8] = msg[8*i+b];
                else              w[63-8*b -: 8] = 8'($urandom);
            end
            nb_drive = last ? nb : 4'($urandom_range(0, 15));
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_word(w, last, nb_drive, ok);
            if (ok) begin
                if (last || pos == 7) begin
                    checkOutput("latency_valid", 512'(blk_valid), 512'(1'b1));
                    pos = 0;
                end else begin
                    checkOutput("fill_no_valid", 512'(blk_valid), 512'(1'b0));
                    pos++;
                end
            end
        end
        nexp = (len + 64 + ((64 - (len % 64)) % 64)) / 64;
        wait_blocks(nexp);
    endtask

    // blk_ready driver: always ready, random, or stalled.
    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0:       blk_ready = 1'b1;
                1:       blk_ready = ($urandom_range(0, 2) != 0);
                default: blk_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: records handshaken blocks, checks that a stalled block
    // holds still and that no input is taken while a block is presented.
    initial begin
        logic         hold_chk;
        logic [511:0] hold_data;
        logic         hold_last;
        blk_t         blk;
        hold_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    checkOutput("hold_data", blk_data, hold_data);
                    checkOutput("hold_valid_last", 512'({blk_valid, blk_last}),
                                512'({1'b1, hold_last}));
                end
                if (blk_valid) begin
                    checkOutput("in_ready_while_valid", 512'(in_ready), 512'(1'b0));
                end
                if (blk_valid && blk_ready) begin
                    blk.data = blk_data;
                    blk.last = blk_last;
                    obs_q.push_back(blk);
                end
                hold_chk  = blk_valid && !blk_ready;
                hold_data = blk_data;
                hold_last = blk_last;
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vt[8];
        msg_q_t      msg;
        logic [511:0] d0;
        bit          ok;
        int          budget;

        vt[0] = '{"empty",  0, 0, 1, 64'h8000000000000000, 128'h0};
        vt[1] = '{"abc",    3, 0, 2, 64'h6162638000000000, 128'h18};
        vt[2] = '{"b64",   64, 1, 2, 64'h0001020304050607, 128'h200};
        vt[3] = '{"b72",   72, 1, 3, 64'h0001020304050607, 128'h240};
        vt[4] = '{"b8",     8, 1, 2, 64'h0001020304050607, 128'h40};
        vt[5] = '{"b63",   63, 1, 2, 64'h0001020304050607, 128'h1F8};
        vt[6] = '{"b56",   56, 1, 2, 64'h0001020304050607, 128'h1C0};
        vt[7] = '{"b65",   65, 1, 3, 64'h0001020304050607, 128'h208};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bytes  = '0;
        sink_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reset_in_ready_low", 512'(in_ready), 512'(1'b0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_in_ready_high", 512'(in_ready), 512'(1'b1));
        checkOutput("reset_blk_valid", 512'(blk_valid), 512'(1'b0));
        checkOutput("reset_blk_last", 512'(blk_last), 512'(1'b0));
        checkOutput("reset_blk_data", blk_data, 512'(0));

        // Table-driven directed messages.
        for (int t = 0; t < 8; t++) begin
            msg.delete();
            for (int i = 0; i < vt[t].nbytes; i++) begin
                msg.push_back(vt[t].pattern == 0 ? 8'(8'h61 + i) : 8'(i % 8));
            end
            applyStimulus(msg, 1'b0, 1'b0);
            checkOutput({vt[t].name, "_nblk_const"}, 512'(obs_q.size()), 512'(vt[t].exp_nblk));
            if (obs_q.size() > 0) begin
                checkOutput({vt[t].name, "_word0"}, 512'(obs_q[0].data[511:448]),
                            512'(vt[t].exp_word0));
                checkOutput({vt[t].name, "_lenfield"},
                            512'(obs_q[obs_q.size()-1].data[127:0]), 512'(vt[t].exp_len));
            end
            compare_model(vt[t].name, msg);
        end

        // Reset in the middle of a message, then "abc".
        for (int i = 0; i < 3; i++) send_word(64'h0001020304050607, 1'b0, 4'd8, ok);
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready_low", 512'(in_ready), 512'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready_high", 512'(in_ready), 512'(1'b1));
        checkOutput("midrst_blk_valid", 512'(blk_valid), 512'(1'b0));
        checkOutput("midrst_blk_data", blk_data, 512'(0));
        @(posedge clk);
        #1;
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        applyStimulus(msg, 1'b0, 1'b0);
        if (obs_q.size() == 2) begin
            checkOutput("midrst_abc_blk0", obs_q[0].data, {64'h6162638000000000, 448'h0});
            checkOutput("midrst_abc_blk1", obs_q[1].data, {384'h0, 128'h18});
        end
        compare_model("midrst_abc", msg);

        // Backpressure on a 64-byte message, with a word offered during the stall.
        obs_q.delete();
        sink_mode = 2;
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'(i % 8));
        for (int i = 0; i < 8; i++) send_word(64'h0001020304050607, i == 7, 4'd8, ok);
        checkOutput("bp_latency", 512'(blk_valid), 512'(1'b1));
        d0       = blk_data;
        in_data  = 64'hDEADBEEFCAFEF00D;
        in_last  = 1'b1;
        in_bytes = 4'd8;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("bp_data_stable", blk_data, d0);
            checkOutput("bp_valid_held", 512'(blk_valid), 512'(1'b1));
            checkOutput("bp_in_ready", 512'(in_ready), 512'(1'b0));
        end
        in_valid  = 1'b0;
        sink_mode = 0;
        budget    = 0;
        wait_blocks(2);
        compare_model("backpressure", msg);

        // The stalled word must not have leaked into the next message.
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        applyStimulus(msg, 1'b0, 1'b0);
        compare_model("post_bp_abc", msg);

        // Randomised messages with input gaps and random blk_ready.
        sink_mode = 1;
        for (int m = 0; m < 40; m++) begin
            int len;
            bit tail;
            case ($urandom_range(0, 3))
                0:       len = 64 * $urandom_range(0, 3);
                1:       len = 8 * $urandom_range(0, 25);
                default: len = $urandom_range(0, 200);
            endcase
            msg.delete();
            repeat (len) msg.push_back(8'($urandom));
            tail = (len % 8 == 0 && len > 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            applyStimulus(msg, tail, 1'b1);
            compare_model("rand", msg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
